// File: rtl/input_ctrl_mc.sv
// Multi-channel FIR input tap line.
// Time-interleaved samples for NUM_CH channels arrive on one valid/ready stream.
// Each channel keeps its own DEPTH-tap signed delay line. After each accepted
// sample the full window of the channel just written is presented downstream,
// together with a primed flag.
module input_ctrl_mc #(
    parameter int DATA_W = 8,
    parameter int DEPTH = 152,
    parameter int NUM_CH = 2,
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     clk_enable,
    input  logic                     clear,
    input  logic signed [DATA_W-1:0] in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [DEPTH*DATA_W-1:0]  out_taps,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [CH_W-1:0]          out_ch,
    output logic                     out_primed
);

    localparam int FILL_W = $clog2(DEPTH + 1);

    logic signed [DATA_W-1:0] line [NUM_CH][DEPTH];
    logic [FILL_W-1:0]        fill [NUM_CH];
    logic [CH_W-1:0]          wr_ch;
    logic                     accept;
    logic [FILL_W:0]          fill_inc;

    // Fill counters stop at DEPTH; one extra bit in the increment avoids wrap.
    function automatic logic [FILL_W-1:0] sat_fill(input logic [FILL_W:0] v);
        if (v > (FILL_W+1)'(DEPTH)) begin
            return FILL_W'(DEPTH);
        end
        return v[FILL_W-1:0];
    endfunction

    // Round-robin channel pointer; a single channel pins it at 0.
    function automatic logic [CH_W-1:0] next_ch(input logic [CH_W-1:0] ch);
        if (NUM_CH == 1) begin
            return '0;
        end
        return (ch == CH_W'(NUM_CH - 1)) ? '0 : ch + CH_W'(1);
    endfunction

    // A new window may only be launched when the current one is gone or being consumed.
    assign in_ready = reset_n & clk_enable & (~out_valid | out_ready);
    assign accept   = in_valid & in_ready & ~clear;
    assign fill_inc = {1'b0, fill[wr_ch]} + (FILL_W+1)'(1);

    // Delay-line storage: only the channel being written shifts.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int c = 0; c < NUM_CH; c++) begin
                for (int k = 0; k < DEPTH; k++) begin
                    line[c][k] <= '0;
                end
            end
        end else if (clk_enable) begin
            if (clear) begin
                for (int c = 0; c < NUM_CH; c++) begin
                    for (int k = 0; k < DEPTH; k++) begin
                        line[c][k] <= '0;
                    end
                end
            end else if (accept) begin
                for (int c = 0; c < NUM_CH; c++) begin
                    if (CH_W'(c) == wr_ch) begin
                        for (int k = DEPTH - 1; k > 0; k--) begin
                            line[c][k] <= line[c][k-1];
                        end
                        line[c][0] <= in_data;
                    end
                end
            end
        end
    end

    // Control: fill counters, write pointer and the output handshake registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int c = 0; c < NUM_CH; c++) begin
                fill[c] <= '0;
            end
            wr_ch      <= '0;
            out_valid  <= 1'b0;
            out_ch     <= '0;
            out_primed <= 1'b0;
        end else if (clk_enable) begin
            if (clear) begin
                for (int c = 0; c < NUM_CH; c++) begin
                    fill[c] <= '0;
                end
                wr_ch      <= '0;
                out_valid  <= 1'b0;
                out_primed <= 1'b0;
            end else if (accept) begin
                for (int c = 0; c < NUM_CH; c++) begin
                    if (CH_W'(c) == wr_ch) begin
                        fill[c] <= sat_fill(fill_inc);
                    end
                end
                out_ch     <= wr_ch;
                out_valid  <= 1'b1;
                out_primed <= (fill_inc >= (FILL_W+1)'(DEPTH));
                wr_ch      <= next_ch(wr_ch);
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    // Window is read straight from storage; it cannot change while a window is stalled.
    always_comb begin
        out_taps = '0;
        for (int k = 0; k < DEPTH; k++) begin
            out_taps[k*DATA_W +: DATA_W] = line[out_ch][k];
        end
    end

endmodule

// File: tb/tb_input_ctrl_mc.sv
// Bench for input_ctrl_mc: scoreboard of expected windows built from a
// per-channel sample history, with directed and randomized stimulus.
module tb_input_ctrl_mc;

    localparam int DATA_W = 8;
    localparam int DEPTH = 4;
    localparam int NUM_CH = 2;
    localparam int CH_W = 1;
    localparam int TW = DEPTH * DATA_W;

    logic                     clk;
    logic                     reset_n;
    logic                     clk_enable;
    logic                     clear;
    logic signed [DATA_W-1:0] in_data;
    logic                     in_valid;
    logic                     in_ready;
    logic [TW-1:0]            out_taps;
    logic                     out_valid;
    logic                     out_ready;
    logic [CH_W-1:0]          out_ch;
    logic                     out_primed;

    input_ctrl_mc #(.DATA_W(DATA_W), .DEPTH(DEPTH), .NUM_CH(NUM_CH)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .clk_enable(clk_enable),
        .clear(clear),
        .in_data(in_data),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .out_taps(out_taps),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_ch(out_ch),
        .out_primed(out_primed)
    );

    typedef struct {
        int            ch;
        logic [TW-1:0] taps;
        bit            primed;
    } exp_t;

    exp_t              sbq[$];
    logic [DATA_W-1:0] hist[NUM_CH][$];
    int                m_cnt;
    bit                m_ov;
    int                n_tests;
    int                n_fail;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_flush();
        for (int c = 0; c < NUM_CH; c++) hist[c].delete();
        sbq.delete();
        m_cnt = 0;
        m_ov = 0;
    endtask

    // Reference model: sample history per channel, window = newest DEPTH samples.
    always @(posedge clk) begin
        if (reset_n && clk_enable) begin
            if (clear) begin
                model_flush();
            end else if (in_valid && (!m_ov || out_ready)) begin
                exp_t e;
                int   ch;
                int   sz;
                ch = m_cnt % NUM_CH;
                hist[ch].push_back(in_data);
                if (hist[ch].size() > DEPTH) void'(hist[ch].pop_front());
                sz = hist[ch].size();
                e.ch = ch;
                e.taps = '0;
                for (int k = 0; k < sz; k++) e.taps[k*DATA_W +: DATA_W] = hist[ch][sz-1-k];
                e.primed = (sz >= DEPTH);
                sbq.push_back(e);
                m_cnt++;
                m_ov = 1;
            end else if (m_ov && out_ready) begin
                m_ov = 0;
            end
        end
    end

    always @(negedge reset_n) model_flush();

    // Monitor: checks handshake every cycle, compares each presented window.
    always @(negedge clk) begin
        chk("in_ready", 64'(in_ready), 64'(reset_n && clk_enable && (!m_ov || out_ready)));
        chk("out_valid", 64'(out_valid), 64'(m_ov));
        if (out_valid === 1'b1) begin
            if (sbq.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL sb_empty: got out_valid=1 expected no pending window at %0t", $time);
            end else begin
                chk("out_ch", 64'(out_ch), 64'(sbq[0].ch));
                chk("out_taps", 64'(out_taps), 64'(sbq[0].taps));
                chk("out_primed", 64'(out_primed), 64'(sbq[0].primed));
                if (out_ready && clk_enable) void'(sbq.pop_front());
            end
        end
    end

    task automatic drive(input bit v, input logic [DATA_W-1:0] d, input bit rdy, input bit clr, input bit en);
        @(posedge clk);
        #1;
        in_valid = v;
        in_data = d;
        out_ready = rdy;
        clear = clr;
        clk_enable = en;
    endtask

    initial begin
        n_tests = 0;
        n_fail = 0;
        m_cnt = 0;
        m_ov = 0;
        reset_n = 1'b0;
        clk_enable = 1'b1;
        clear = 1'b0;
        in_valid = 1'b0;
        in_data = '0;
        out_ready = 1'b0;

        // Reset and idle
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'(0));
        reset_n = 1'b1;
        #2;
        chk("idle_out_valid", 64'(out_valid), 64'(0));
        chk("idle_in_ready", 64'(in_ready), 64'(1));
        chk("idle_taps", 64'(out_taps), 64'(0));
        chk("idle_out_ch", 64'(out_ch), 64'(0));
        chk("idle_primed", 64'(out_primed), 64'(0));

        // Interleave 1..9, back-to-back
        for (int i = 1; i <= 9; i++) drive(1, DATA_W'(i), 1, 0, 1);
        drive(0, '0, 1, 0, 1);
        chk("s9_taps", 64'(out_taps), 64'(32'h03050709));
        chk("s9_ch", 64'(out_ch), 64'(0));
        chk("s9_primed", 64'(out_primed), 64'(1));

        // Backpressure: one accept, then stall with in_valid held
        drive(1, 8'h11, 0, 0, 1);
        repeat (6) drive(1, 8'h22, 0, 0, 1);
        drive(1, 8'h22, 1, 0, 1);

        // Signed extremes into the same channel
        drive(1, 8'h80, 1, 0, 1);
        drive(1, 8'h00, 1, 0, 1);
        drive(1, 8'h7F, 1, 0, 1);
        drive(1, 8'h01, 1, 0, 1);
        drive(0, '0, 1, 0, 1);

        // Clear coincident with a valid sample
        drive(1, 8'h05, 1, 0, 1);
        drive(1, 8'h55, 1, 1, 1);
        drive(1, 8'h06, 1, 0, 1);
        drive(0, '0, 0, 0, 1);
        chk("clr_ch", 64'(out_ch), 64'(0));
        chk("clr_primed", 64'(out_primed), 64'(0));
        chk("clr_taps", 64'(out_taps), 64'(32'h00000006));

        // Enable low: in_valid and clear ignored, pending window held
        repeat (3) drive(1, 8'h77, 1, 1, 0);
        drive(0, '0, 0, 0, 1);
        chk("en_hold_taps", 64'(out_taps), 64'(32'h00000006));

        // Async reset pulse between edges while a window is pending
        drive(1, 8'h33, 1, 0, 1);
        drive(0, '0, 0, 0, 1);
        #2;
        chk("pre_rst_valid", 64'(out_valid), 64'(1));
        reset_n = 1'b0;
        #1;
        chk("async_rst_valid", 64'(out_valid), 64'(0));
        chk("async_rst_taps", 64'(out_taps), 64'(0));
        reset_n = 1'b1;

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            drive($urandom_range(0, 9) < 7,
                  DATA_W'($urandom_range(0, 255)),
                  $urandom_range(0, 9) < 7,
                  $urandom_range(0, 49) == 0,
                  $urandom_range(0, 9) != 0);
        end

        // Drain
        repeat (5) drive(0, '0, 1, 0, 1);
        chk("sb_drained", 64'(sbq.size()), 64'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/input_ctrl_mc.md
Name: input_ctrl_mc

Overview:
Parametrised multi-channel successor to the FIR input tap line. Time-interleaved samples for NUM_CH channels arrive on one valid/ready stream. Each channel has its own DEPTH-tap signed delay line. After each accepted sample, the block presents the full tap window of the channel just written, with a primed flag, to the downstream SC/MAC stage.

Parameters:
DATA_W, 8, sample width in bits (signed; sfix8_En7 at default).
DEPTH, 152, taps per channel.
NUM_CH, 2, number of interleaved channels, at least 1.
CH_W (localparam), NUM_CH>1 ? clog2(NUM_CH) : 1, width of the channel index.

Ports:
clk  in  1  rising-edge clock
reset_n  in  1  asynchronous active-low reset
clk_enable  in  1  global enable; when 0 all state freezes
clear  in  1  synchronous flush of all delay lines and counters
in_data  in  DATA_W  signed input sample
in_valid  in  1  in_data is valid
in_ready  out  1  block can accept a sample this cycle
out_taps  out  DEPTH*DATA_W  window of channel out_ch; tap k (k=0 newest) at bits [k*DATA_W +: DATA_W]
out_valid  out  1  out_taps/out_ch/out_primed are valid
out_ready  in  1  downstream consumes the window
out_ch  out  CH_W  channel of the presented window
out_primed  out  1  channel out_ch has received at least DEPTH samples since reset/clear

Behaviour:
- Reset (reset_n=0, async): all taps of all channels = 0, all fill counters = 0, write channel counter wr_ch = 0, out_valid = 0, out_ch = 0, out_primed = 0. in_ready = 0 while reset_n=0.
- in_ready = clk_enable & (!out_valid | out_ready). This is combinational; there is no combinational path from in_valid.
- Accept happens when in_valid & in_ready & !clear. On the accepting edge:
  - line[wr_ch] shifts: tap0 <= in_data, tap k <= tap k-1, and tap DEPTH-1 is discarded.
  - fill[wr_ch] increments and saturates at DEPTH.
  - out_ch <= wr_ch; out_valid <= 1; out_primed <= (fill[wr_ch]+1 >= DEPTH).
  - wr_ch <= wr_ch+1, wrapping at NUM_CH-1 -> 0.
- Latency is 1 cycle from the accept edge to out_valid=1 with the updated window.
- out_taps = line[out_ch], read combinationally from storage with no copy register. It is stable while out_valid & !out_ready, because no accept can occur in that state.
- Consume without accept (out_valid & out_ready and no accept): out_valid <= 0.
- Consume with simultaneous accept: out_valid stays 1 and out_ch/out_taps update to the new channel. This gives back-to-back throughput of 1 sample/cycle.
- Other channels' lines are never modified by an accept.
- clear=1 with clk_enable=1: on that edge all taps = 0, fill = 0, wr_ch = 0, out_valid = 0, out_primed = 0. clear has priority over a coincident accept; that sample is dropped, and in_ready is not gated by clear.
- clk_enable=0: no state changes, including clear. Outputs hold, in_ready = 0, and a pending out_valid remains asserted.
- NUM_CH=1: wr_ch and out_ch are constant 0; behaviour is a single delay line with handshake.
- Arithmetic: no arithmetic is performed on samples; values pass bit-exact and sign is preserved.
- Fill counter width is clog2(DEPTH+1).

Test Plan:
- Reset/idle: deassert reset_n with no input -> out_valid=0, in_ready=1, out_taps all 0, out_ch=0, out_primed=0.
- Interleave, NUM_CH=2, DEPTH=4: feed 1,2,3,4,5,6,7,8 with out_ready=1.
  - Each is presented one cycle later, and out_ch alternates 0,1,0,1.
  - After sample 7, ch0 taps = {7,5,3,1} (tap0..3) with out_primed=1.
  - After 8, ch1 taps = {8,6,4,2}.
  - Sample 9 (ch0) gives taps {9,7,5,3}.
- Backpressure: hold out_ready=0 after one accept -> in_ready=0. in_valid stays high but no second sample is taken, and out_taps/out_ch stay stable for 5 cycles. Raising out_ready accepts the next sample on the same edge.
- Signed extremes: feed -128 (0x80) and 127 (0x7F) -> appear bit-exact in tap0 then tap1 of the same channel.
- Clear and enable: issue clear together with in_valid mid-stream -> sample dropped, all taps 0, next accept goes to ch0 with out_primed=0. With clk_enable=0, asserting in_valid and clear for 3 cycles leaves state unchanged.
- Async reset mid-stream: pulse reset_n low between edges while out_valid=1 -> out_valid=0 immediately (before the next clk edge) and all taps 0.
